// File: rtl/alu_pkg.sv
//------------------------------------------------------------------------------
// alu_pkg: op codes, FSM states and flag bundle shared by the seq_alu design.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

    localparam logic [4:0] ALU_ADDU    = 5'b00000;
    localparam logic [4:0] ALU_SUBU    = 5'b00001;
    localparam logic [4:0] ALU_ADD     = 5'b00010;
    localparam logic [4:0] ALU_SUB     = 5'b00011;
    localparam logic [4:0] ALU_AND     = 5'b00100;
    localparam logic [4:0] ALU_OR      = 5'b00101;
    localparam logic [4:0] ALU_XOR     = 5'b00110;
    localparam logic [4:0] ALU_NOR     = 5'b00111;
    localparam logic [4:0] ALU_LUI     = 5'b01000;
    localparam logic [4:0] ALU_LUI_ALT = 5'b01001;
    localparam logic [4:0] ALU_SLTU    = 5'b01010;
    localparam logic [4:0] ALU_SLT     = 5'b01011;
    localparam logic [4:0] ALU_SRA     = 5'b01100;
    localparam logic [4:0] ALU_SRL     = 5'b01101;
    localparam logic [4:0] ALU_SLL     = 5'b01110;
    localparam logic [4:0] ALU_SLL_ALT = 5'b01111;
    localparam logic [4:0] ALU_MUL     = 5'b10000;
    localparam logic [4:0] ALU_MULU    = 5'b10001;
    localparam logic [4:0] ALU_DIV     = 5'b10010;
    localparam logic [4:0] ALU_DIVU    = 5'b10011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic zero;
        logic carry;
        logic negative;
        logic overflow;
    } alu_flags_t;

endpackage

`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
//------------------------------------------------------------------------------
// alu_muldiv_iter: WIDTH-step shift-add multiplier / restoring divider on one adder.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             dz
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] LAST = (SHW+1)'(WIDTH - 1);

    logic             running;
    logic             div_mode;
    logic             neg_lo;
    logic             neg_hi;
    logic [SHW:0]     cnt;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] hi_nx;
    logic [WIDTH-1:0] lo_nx;
    logic [2*WIDTH-1:0] prod;

    // Both algorithms work on magnitudes; signs are restored on the way out.
    always_comb begin
        a_neg = is_signed && a[WIDTH-1];
        b_neg = is_signed && b[WIDTH-1];
        a_mag = a_neg ? (~a + 1'b1) : a;
        b_mag = b_neg ? (~b + 1'b1) : b;
    end

    // Divide reuses the adder as a subtractor: x + ~d + 1, carry-out = no borrow.
    always_comb begin
        add_x = div_mode ? {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]} : acc_hi;
        add_y = div_mode ? ~opnd : opnd;
        sum   = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, div_mode};
        hi_nx = acc_hi;
        lo_nx = acc_lo;
        if (div_mode) begin
            if (acc_hi[WIDTH-1] || sum[WIDTH]) begin
                hi_nx = sum[WIDTH-1:0];
                lo_nx = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_nx = add_x;
                lo_nx = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else if (acc_lo[0]) begin
            {hi_nx, lo_nx} = {sum, acc_lo[WIDTH-1:1]};
        end else begin
            {hi_nx, lo_nx} = {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
        end
    end

    always_comb begin
        dz   = div_mode && (opnd == '0);
        prod = {hi_nx, lo_nx};
        if (div_mode) begin
            lo = dz ? '1 : (neg_lo ? (~lo_nx + 1'b1) : lo_nx);
            hi = neg_hi ? (~hi_nx + 1'b1) : hi_nx;
        end else begin
            {hi, lo} = neg_lo ? (~prod + 1'b1) : prod;
        end
        done = running && (cnt == LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            running  <= 1'b0;
            div_mode <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
        end else if (start) begin
            running  <= 1'b1;
            div_mode <= is_div;
            neg_lo   <= a_neg ^ b_neg;
            neg_hi   <= is_div && a_neg;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= a_mag;
            opnd     <= b_mag;
        end else if (running) begin
            acc_hi <= hi_nx;
            acc_lo <= lo_nx;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
                running <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
//------------------------------------------------------------------------------
// seq_alu: registered valid/ready ALU with iterative mul/div; ALU_DIV_EN builds div.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] r_hi,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic             overflow,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    state_t     state;
    state_t     state_nx;
    alu_flags_t flags;
    alu_flags_t sc_f;
    alu_flags_t md_f;
    logic [WIDTH-1:0] sc_r;

    logic accept;
    logic is_mul;
    logic is_div;
    logic is_md;
    logic min_ovf;
    logic div_op;
    logic div_ovf;

    logic             md_done;
    logic             md_dz;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;

    logic [SHW-1:0] sh;
    logic [WIDTH:0] sum_ext;
    logic [WIDTH:0] dif_ext;
    logic [WIDTH:0] sll_ext;
    logic [WIDTH:0] srl_ext;
    logic [WIDTH:0] sra_ext;
    logic           lt_s;
    logic           lt_u;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY);
    assign accept    = in_valid && in_ready;
    assign zero      = flags.zero;
    assign carry     = flags.carry;
    assign negative  = flags.negative;
    assign overflow  = flags.overflow;

    always_comb begin
        is_mul = (op == ALU_MUL) || (op == ALU_MULU);
`ifdef ALU_DIV_EN
        is_div = (op == ALU_DIV) || (op == ALU_DIVU);
`else
        is_div = 1'b0;
`endif
        is_md   = is_mul || is_div;
        min_ovf = is_div && !op[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (accept && is_md),
        .is_signed (!op[0]),
        .is_div    (is_div),
        .a         (a),
        .b         (b),
        .done      (md_done),
        .lo        (md_lo),
        .hi        (md_hi),
        .dz        (md_dz)
    );

    // Shifts run one bit wider so the last bit shifted out lands in a fixed slot.
    always_comb begin
        sh      = a[SHW-1:0];
        sum_ext = {1'b0, a} + {1'b0, b};
        dif_ext = {1'b0, a} - {1'b0, b};
        sll_ext = {1'b0, b} << sh;
        srl_ext = {b, 1'b0} >> sh;
        sra_ext = $signed({b, 1'b0}) >>> sh;
        lt_s    = $signed(a) < $signed(b);
        lt_u    = a < b;
    end

    always_comb begin
        sc_r = '0;
        sc_f = '0;
        case (op)
            ALU_ADDU: begin
                sc_r       = sum_ext[WIDTH-1:0];
                sc_f.carry = sum_ext[WIDTH];
            end
            ALU_ADD: begin
                sc_r          = sum_ext[WIDTH-1:0];
                sc_f.overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sc_r[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUBU: begin
                sc_r       = dif_ext[WIDTH-1:0];
                sc_f.carry = dif_ext[WIDTH];
            end
            ALU_SUB: begin
                sc_r          = dif_ext[WIDTH-1:0];
                sc_f.overflow = (a[WIDTH-1] != b[WIDTH-1]) && (sc_r[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND:                sc_r = a & b;
            ALU_OR:                 sc_r = a | b;
            ALU_XOR:                sc_r = a ^ b;
            ALU_NOR:                sc_r = ~(a | b);
            ALU_LUI, ALU_LUI_ALT:   sc_r = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            ALU_SLTU:               sc_r = {{(WIDTH-1){1'b0}}, lt_u};
            ALU_SLT:                sc_r = {{(WIDTH-1){1'b0}}, lt_s};
            ALU_SRA: begin
                sc_r       = sra_ext[WIDTH:1];
                sc_f.carry = sra_ext[0];
            end
            ALU_SRL: begin
                sc_r       = srl_ext[WIDTH:1];
                sc_f.carry = srl_ext[0];
            end
            ALU_SLL, ALU_SLL_ALT: begin
                sc_r       = sll_ext[WIDTH-1:0];
                sc_f.carry = sll_ext[WIDTH];
            end
            default:                sc_f.overflow = 1'b1;
        endcase
        if (!op[4]) begin
            sc_f.zero     = (sc_r == '0);
            sc_f.negative = sc_r[WIDTH-1];
            if (op == ALU_SLT || op == ALU_SLTU) begin
                sc_f.zero     = (a == b);
                sc_f.negative = sc_r[0];
            end
        end
    end

    always_comb begin
        md_f          = '0;
        md_f.zero     = ({md_hi, md_lo} == '0);
        md_f.negative = div_op ? md_lo[WIDTH-1] : md_hi[WIDTH-1];
        md_f.overflow = div_op && (md_dz || div_ovf);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = is_md ? BUSY : DONE;
            BUSY:    if (md_done) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r       <= '0;
            r_hi    <= '0;
            flags   <= '0;
            div_op  <= 1'b0;
            div_ovf <= 1'b0;
        end else if (accept) begin
            div_op  <= is_div;
            div_ovf <= min_ovf;
            if (!is_md) begin
                r     <= sc_r;
                r_hi  <= '0;
                flags <= sc_f;
            end
        end else if (state == BUSY && md_done) begin
            r     <= md_lo;
            r_hi  <= md_hi;
            flags <= md_f;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
//------------------------------------------------------------------------------
// tb_seq_alu: directed table plus randomized ops against a behavioural model.
// Rev 1.0 - division expectations follow ALU_DIV_EN.
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_alu;

    localparam logic [4:0] OP_ADDU = 5'b00000;
    localparam logic [4:0] OP_SUBU = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00011;
    localparam logic [4:0] OP_NOR  = 5'b00111;
    localparam logic [4:0] OP_LUI  = 5'b01000;
    localparam logic [4:0] OP_SLTU = 5'b01010;
    localparam logic [4:0] OP_SLT  = 5'b01011;
    localparam logic [4:0] OP_SRA  = 5'b01100;
    localparam logic [4:0] OP_SRL  = 5'b01101;
    localparam logic [4:0] OP_SLL  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_MULU = 5'b10001;
    localparam logic [4:0] OP_DIV  = 5'b10010;
    localparam logic [4:0] OP_DIVU = 5'b10011;

    typedef struct {
        logic [31:0] r;
        logic [31:0] hi;
        logic [3:0]  f;
        int          lat;
    } exp_t;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;
        int          hold;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] r;
    logic [31:0] r_hi;
    logic        zero;
    logic        carry;
    logic        negative;
    logic        overflow;
    logic        busy;

    int passed = 0;
    int total  = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .r_hi      (r_hi),
        .zero      (zero),
        .carry     (carry),
        .negative  (negative),
        .overflow  (overflow),
        .busy      (busy)
    );

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic exp_t mk(input logic [31:0] rr, input logic [31:0] hh,
                                input logic [3:0] ff, input int lat);
        exp_t e;
        e.r = rr; e.hi = hh; e.f = ff; e.lat = lat;
        return e;
    endfunction

    task automatic add_vec(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                           input exp_t e, input int hold);
        vec_t v;
        v.op = o; v.a = x; v.b = y; v.e = e; v.hold = hold;
        vecs.push_back(v);
    endtask

    // Reference model: plain 64-bit arithmetic on the operation's definition.
    function automatic exp_t model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        longint sa = longint'($signed(x));
        longint sb = longint'($signed(y));
        longint unsigned ua = longint'(x);
        longint unsigned ub = longint'(y);
        longint t;
        logic [63:0] p;
        int sh = int'(x[4:0]);
        logic z = 1'b0, c = 1'b0, n = 1'b0, v = 1'b0, lt = 1'b0;
        bit cmp = 0;
        e.r = '0; e.hi = '0; e.lat = 1;
        case (o)
            5'b00000: begin p = ua + ub; e.r = p[31:0]; c = p[32]; end
            5'b00010: begin t = sa + sb; e.r = t[31:0]; v = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
            5'b00001: begin e.r = x - y; c = (ua < ub); end
            5'b00011: begin t = sa - sb; e.r = t[31:0]; v = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
            5'b00100: e.r = x & y;
            5'b00101: e.r = x | y;
            5'b00110: e.r = x ^ y;
            5'b00111: e.r = ~(x | y);
            5'b01000, 5'b01001: e.r = {y[15:0], 16'h0000};
            5'b01010: begin lt = (ua < ub); cmp = 1; end
            5'b01011: begin lt = (sa < sb); cmp = 1; end
            5'b01100: begin t = sb >>> sh; e.r = t[31:0]; c = (sh != 0) && y[sh-1]; end
            5'b01101: begin e.r = y >> sh; c = (sh != 0) && y[sh-1]; end
            5'b01110, 5'b01111: begin e.r = y << sh; c = (sh != 0) && y[32-sh]; end
            5'b10000, 5'b10001: begin
                p = (o == 5'b10000) ? 64'(sa * sb) : 64'(ua * ub);
                e.r = p[31:0]; e.hi = p[63:32];
                z = (p == 0); n = p[63]; e.lat = 33;
            end
            5'b10010, 5'b10011: begin
`ifdef ALU_DIV_EN
                if (y == 0) begin
                    e.r = '1; e.hi = x; v = 1'b1;
                end else if (o == 5'b10010 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    e.r = x; e.hi = 0; v = 1'b1;
                end else if (o == 5'b10010) begin
                    t = sa / sb; e.r = t[31:0];
                    t = sa % sb; e.hi = t[31:0];
                end else begin
                    p = ua / ub; e.r = p[31:0];
                    p = ua % ub; e.hi = p[31:0];
                end
                z = ({e.hi, e.r} == 0); n = e.r[31]; e.lat = 33;
`else
                v = 1'b1;
`endif
            end
            default: v = 1'b1;
        endcase
        if (!o[4]) begin
            if (cmp) e.r = {31'b0, lt};
            z = cmp ? (x == y) : (e.r == 0);
            n = cmp ? lt : e.r[31];
        end
        e.f = {z, c, n, v};
        return e;
    endfunction

    task automatic run_op(input string nm, input logic [4:0] o, input logic [31:0] x,
                          input logic [31:0] y, input exp_t e, input int hold);
        int cyc;
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        check({nm, " busy/in_ready"}, {busy, in_ready}, (e.lat > 1) ? 2'b10 : 2'b00);
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({nm, " latency"}, cyc, e.lat);
        check({nm, " r"}, r, e.r);
        check({nm, " r_hi"}, r_hi, e.hi);
        check({nm, " flags"}, {zero, carry, negative, overflow}, e.f);
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1; op = OP_ADDU; a = ~x; b = 32'd1;
            @(posedge clk); #1;
            check({nm, " hold"}, {out_valid, in_ready, busy, r, r_hi, zero, carry, negative, overflow},
                  {3'b100, e.r, e.hi, e.f});
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({nm, " release"}, {out_valid, in_ready}, 2'b01);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [4:0]  ro;
        logic [31:0] ra, rb;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset state", {out_valid, busy, in_ready, r, r_hi, zero, carry, negative, overflow},
              {3'b001, 64'h0, 4'h0});

        add_vec(OP_ADDU, 32'hFFFF_FFFF, 32'h1,         mk(32'h0,         32'h0, 4'b1100, 1), 0);
        add_vec(OP_ADD,  32'h7FFF_FFFF, 32'h1,         mk(32'h8000_0000, 32'h0, 4'b0011, 1), 0);
        add_vec(OP_SRA,  32'h4,         32'hF000_0008, mk(32'hFF00_0000, 32'h0, 4'b0110, 1), 0);
        add_vec(OP_SLL,  32'h0,         32'h8000_0001, mk(32'h8000_0001, 32'h0, 4'b0010, 1), 0);
        add_vec(OP_SLL,  32'h1,         32'h8000_0001, mk(32'h0000_0002, 32'h0, 4'b0100, 1), 0);
        add_vec(OP_SRL,  32'h25,        32'h0000_00F0, mk(32'h0000_0007, 32'h0, 4'b0100, 1), 0);
        add_vec(OP_SLT,  32'hFFFF_FFFF, 32'h1,         mk(32'h1,         32'h0, 4'b0010, 1), 0);
        add_vec(OP_SLTU, 32'hFFFF_FFFF, 32'h1,         mk(32'h0,         32'h0, 4'b0000, 1), 1);
        add_vec(OP_SUBU, 32'h1,         32'h2,         mk(32'hFFFF_FFFF, 32'h0, 4'b0110, 1), 0);
        add_vec(OP_SUB,  32'h8000_0000, 32'h1,         mk(32'h7FFF_FFFF, 32'h0, 4'b0001, 1), 0);
        add_vec(OP_LUI,  32'h0,         32'h1234_ABCD, mk(32'hABCD_0000, 32'h0, 4'b0010, 1), 0);
        add_vec(OP_NOR,  32'h0,         32'h0,         mk(32'hFFFF_FFFF, 32'h0, 4'b0010, 1), 0);
        add_vec(OP_MUL,  32'hFFFF_FFFD, 32'h5,         mk(32'hFFFF_FFF1, 32'hFFFF_FFFF, 4'b0010, 33), 5);
        add_vec(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'h0000_0001, 32'hFFFF_FFFE, 4'b0010, 33), 0);
`ifdef ALU_DIV_EN
        add_vec(OP_DIVU, 32'd100,       32'd7,         mk(32'd14,        32'd2, 4'b0000, 33), 0);
        add_vec(OP_DIVU, 32'd5,         32'd0,         mk(32'hFFFF_FFFF, 32'd5, 4'b0011, 33), 0);
        add_vec(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, mk(32'h8000_0000, 32'h0, 4'b0011, 33), 0);
        add_vec(OP_DIV,  32'hFFFF_FFF9, 32'd2,         mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 4'b0010, 33), 0);
        add_vec(OP_DIV,  32'd9,         32'd3,         mk(32'd3,         32'h0, 4'b0000, 33), 0);
`else
        add_vec(OP_DIV,  32'd9,         32'd3,         mk(32'h0,         32'h0, 4'b0001, 1), 0);
        add_vec(OP_DIVU, 32'd100,       32'd7,         mk(32'h0,         32'h0, 4'b0001, 1), 0);
`endif
        add_vec(5'b10111, 32'h1234,     32'h5678,      mk(32'h0,         32'h0, 4'b0001, 1), 0);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e, vecs[i].hold);
        end

        // Reset in the middle of a multiply discards it.
        op = OP_MUL; a = 32'hFFFF_FFFD; b = 32'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("mid-mul busy", {busy, out_valid}, 2'b10);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid-mul reset", {out_valid, busy, in_ready, r, r_hi, zero, carry, negative, overflow},
              {3'b001, 64'h0, 4'h0});
        run_op("post-reset addu", OP_ADDU, 32'd2, 32'd3, mk(32'd5, 32'd0, 4'b0000, 1), 0);

        for (int i = 0; i < 60; i++) begin
            ro = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
            ra = pick();
            rb = pick();
            run_op($sformatf("rand%0d op%b", i, ro), ro, ra, rb, model(ro, ra, rb), int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor of the team's combinational 32-bit ALU.
- Keeps the 4-bit ALU op set and adds iterative multiply and divide.
- Uses a valid/ready handshake on both sides, with a registered result and flags.
- Sits between the CPU decode/issue stage and writeback; stalls issue while multi-cycle ops run.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- op  input  5  operation code (see Behaviour)
- a  input  WIDTH  operand A; shift amount for shifts
- b  input  WIDTH  operand B; shifted value for shifts
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- r  output  WIDTH  result; low product / quotient for mul/div
- r_hi  output  WIDTH  high product / remainder; 0 for other ops
- zero  output  1  flag
- carry  output  1  flag
- negative  output  1  flag
- overflow  output  1  flag
- busy  output  1  multi-cycle op in progress

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE; r, r_hi and all flags = 0; out_valid=0; busy=0; in_ready=1.
  - Any in-flight op is discarded.
- Opcodes with op[4]=0 (low four bits):
  - 0000 addu, 0010 add, 0001 subu, 0011 sub
  - 0100 and, 0101 or, 0110 xor, 0111 nor
  - 1000/1001 lui, 1011 slt, 1010 sltu
  - 1100 sra, 1101 srl, 1110/1111 sll
- Opcodes with op[4]=1: 10000 mul (signed), 10001 mulu, 10010 div (signed), 10011 divu; all other op[4]=1 codes are illegal.
- State machine: IDLE, BUSY, DONE.
  - in_ready=1 only in IDLE. A request is accepted on in_valid && in_ready.
  - Single-cycle ops and illegal ops: IDLE -> DONE; outputs registered at the accept edge, so out_valid is visible the next cycle (latency 1).
  - mul/div: IDLE -> BUSY for WIDTH iterations, then DONE; out_valid rises WIDTH+1 cycles after accept. busy=1 only in BUSY.
  - DONE: r, r_hi and flags hold stable while out_ready=0. On out_ready, go to IDLE; out_valid falls the next cycle.
  - No back-to-back overlap: one op in flight at a time.
- Flags for single-cycle ops: zero = (r==0); negative = r[WIDTH-1]. Any flag not listed below is 0.
  - addu: carry = carry-out of the (WIDTH+1)-bit sum.
  - subu: carry = borrow (a<b unsigned).
  - add/sub: overflow = two's-complement overflow (operand sign rule, not magnitude compare).
  - slt/sltu: r = {0..0, lt}; zero = (a==b); negative = lt.
  - Shifts use sh = a[SHW-1:0]; upper bits of a are ignored.
  - sll: carry = b[WIDTH-sh], or 0 when sh=0.
  - srl/sra: carry = b[sh-1], or 0 when sh=0. sra sign-fills from b[WIDTH-1].
  - lui: r = {b[WIDTH/2-1:0], zeros}.
- Flags for mul/div: zero = ({r_hi,r}==0); negative = r_hi[WIDTH-1] for mul and r[WIDTH-1] for div.
  - Signed div truncates toward zero; the remainder takes the dividend's sign.
  - Divide by zero: r = all ones, r_hi = a, overflow=1.
  - Signed MIN / -1: r = MIN, r_hi = 0, overflow=1.
- Illegal op: r = r_hi = 0; all flags 0 except overflow=1.
- in_valid asserted while not IDLE is ignored; no request is queued.

Optional Feature:
- Macro: ALU_DIV_EN.
- Defined: the iterative divider is built and div/divu behave as above.
- Undefined: div/divu are treated as illegal ops (1-cycle, r = r_hi = 0, overflow=1). mul/mulu remain.

Decomposition:
- Package alu_pkg: op-code localparams (ALU_ADDU ... ALU_DIVU), state enum (IDLE/BUSY/DONE), flag-bundle typedef.
- Sub-module alu_muldiv_iter: shift-add multiplier and restoring divider.
  - Interface: start, signed, is_div, a, b -> done, lo, hi, dz.
  - Shares one WIDTH-bit adder and an iteration counter of SHW+1 bits.
- Top level holds the FSM, the single-cycle datapath and the output registers.

Test Plan (WIDTH=32):
- addu a=0xFFFFFFFF, b=1 -> one cycle after accept: r=0, zero=1, carry=1, overflow=0, r_hi=0.
- add a=0x7FFFFFFF, b=1 -> r=0x80000000, overflow=1, negative=1. sra a=4, b=0xF0000008 -> r=0xFF000000, carry=1.
- mul a=-3, b=5 with out_ready held 0 for 5 cycles after out_valid:
  - out_valid rises 33 cycles after accept; r_hi=0xFFFFFFFF, r=0xFFFFFFF1, negative=1.
  - Outputs stay stable and in_ready=0 until out_ready rises.
- divu a=100, b=7 -> r=14, r_hi=2. divu a=5, b=0 -> r=0xFFFFFFFF, r_hi=5, overflow=1. div a=0x80000000, b=-1 -> r=0x80000000, r_hi=0, overflow=1.
- rst_n low at cycle 10 of a mul -> next edge: out_valid=0, busy=0, in_ready=1, outputs 0; a following addu 2+3 returns r=5.
- ALU_DIV_EN undefined; div a=9, b=3 -> 1-cycle result, r=0, r_hi=0, overflow=1. Op 10111 -> same response in both builds.
